// File: rtl/id_ex_reg_pkg.sv
// Shared MIPS pipeline types: the ID/EX control bundle, ALU operation codes and register constants.
package mips_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // A non-valid slot must never carry control that could write the register file or memory.
    function automatic ctrl_t gate_ctrl(input logic valid, input ctrl_t ctrl);
        return valid ? ctrl : CTRL_NOP;
    endfunction

endpackage

// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: ID-stage operands, hazard controls, WB write port and the registered EX view.
interface id_ex_if
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);

    logic              stall;
    logic              flush;

    logic              id_valid;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    ctrl_t             id_ctrl;

    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    ctrl_t             ex_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    // ID side and hazard unit drive the pipeline register.
    modport master (
        output stall, flush,
        output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_ctrl,
        output wb_reg_write, wb_rd, wb_data,
        input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl,
        input  stall_cnt
    );

    // The pipeline register itself.
    modport slave (
        input  stall, flush,
        input  id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_ctrl,
        input  wb_reg_write, wb_rd, wb_data,
        output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl,
        output stall_cnt
    );

endinterface

// File: rtl/id_ex_reg_wb_bypass.sv
// Write-back bypass for one register-file read port: substitutes the WB write data when WB
// is writing the same non-zero register that ID is reading in this cycle.
module wb_bypass
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rd_idx_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] data_o
);

    logic hit;

    // Register 0 is hard-wired to zero, so a WB "write" to it must never be forwarded.
    assign hit    = wb_reg_write_i
                 && (wb_rd_i != REG_AW'(REG_ZERO))
                 && (wb_rd_i == rd_idx_i);

    assign data_o = hit ? wb_data_i : rf_data_i;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures ID operands and control each cycle, with flush (bubble),
// stall (hold), WB-to-ID bypass on both read ports and a saturating stall-cycle counter.
module id_ex_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    id_ex_if.slave  bus
);

    logic              ex_valid_q;
    logic [DATA_W-1:0] ex_pc4_q;
    logic [DATA_W-1:0] ex_rs_data_q;
    logic [DATA_W-1:0] ex_rt_data_q;
    logic [DATA_W-1:0] ex_imm_q;
    logic [REG_AW-1:0] ex_rs_q;
    logic [REG_AW-1:0] ex_rt_q;
    logic [REG_AW-1:0] ex_rd_q;
    ctrl_t             ex_ctrl_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic [DATA_W-1:0] ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_d;
    logic [CNT_W-1:0]  stall_cnt_d;

    wb_bypass #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_bypass_rs (
        .rd_idx_i       (bus.id_rs),
        .rf_data_i      (bus.id_rs_data),
        .wb_reg_write_i (bus.wb_reg_write),
        .wb_rd_i        (bus.wb_rd),
        .wb_data_i      (bus.wb_data),
        .data_o         (ex_rs_data_d)
    );

    wb_bypass #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_bypass_rt (
        .rd_idx_i       (bus.id_rt),
        .rf_data_i      (bus.id_rt_data),
        .wb_reg_write_i (bus.wb_reg_write),
        .wb_rd_i        (bus.wb_rd),
        .wb_data_i      (bus.wb_data),
        .data_o         (ex_rt_data_d)
    );

    // Saturate rather than wrap so a long stall never reads back as a short one.
    assign stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);

    // Priority: flush > stall > capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is a plain flop (no memory array), so all of them
            // can and do take the asynchronous reset.
            ex_valid_q   <= 1'b0;
            ex_pc4_q     <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_ctrl_q    <= CTRL_NOP;
            stall_cnt_q  <= '0;
        end else if (bus.flush) begin
            // Bubble: only validity and control are killed; data fields are don't-care and hold.
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= CTRL_NOP;
        end else if (bus.stall) begin
            stall_cnt_q <= stall_cnt_d;
        end else begin
            // NOTE: non-blocking assignments so every field samples the pre-edge values,
            // independent of statement order.
            ex_valid_q   <= bus.id_valid;
            ex_pc4_q     <= bus.id_pc4;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= bus.id_imm;
            ex_rs_q      <= bus.id_rs;
            ex_rt_q      <= bus.id_rt;
            ex_rd_q      <= bus.id_rd;
            ex_ctrl_q    <= gate_ctrl(bus.id_valid, bus.id_ctrl);
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_pc4     = ex_pc4_q;
    assign bus.ex_rs_data = ex_rs_data_q;
    assign bus.ex_rt_data = ex_rt_data_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_rs      = ex_rs_q;
    assign bus.ex_rt      = ex_rt_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus a per-cycle comparison against a
// behavioural model; a second instance with a 4-bit counter exercises saturation.
module tb_id_ex_reg;
    import mips_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic clk;
    logic rst_n;

    id_ex_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(16)) bus16 ();
    id_ex_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(4))  bus4 ();

    id_ex_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    id_ex_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // Both instances see identical stimulus.
    assign bus4.stall        = bus16.stall;
    assign bus4.flush        = bus16.flush;
    assign bus4.id_valid     = bus16.id_valid;
    assign bus4.id_pc4       = bus16.id_pc4;
    assign bus4.id_rs_data   = bus16.id_rs_data;
    assign bus4.id_rt_data   = bus16.id_rt_data;
    assign bus4.id_imm       = bus16.id_imm;
    assign bus4.id_rs        = bus16.id_rs;
    assign bus4.id_rt        = bus16.id_rt;
    assign bus4.id_rd        = bus16.id_rd;
    assign bus4.id_ctrl      = bus16.id_ctrl;
    assign bus4.wb_reg_write = bus16.wb_reg_write;
    assign bus4.wb_rd        = bus16.wb_rd;
    assign bus4.wb_data      = bus16.wb_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the EX stage must hold, and how many stalls were honoured.
    logic              m_valid;
    logic [DATA_W-1:0] m_pc4, m_rs_data, m_rt_data, m_imm;
    logic [REG_AW-1:0] m_rs, m_rt, m_rd;
    logic [8:0]        m_ctrl;
    int                m_stalls;

    function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] idx,
                                                    input logic [DATA_W-1:0] rf);
        if (bus16.wb_reg_write && bus16.wb_rd != 0 && bus16.wb_rd == idx) return bus16.wb_data;
        return rf;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 0; m_pc4 = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_ctrl = 0; m_stalls = 0;
        end else if (bus16.flush) begin
            m_valid = 0;
            m_ctrl  = 0;
        end else if (bus16.stall) begin
            m_stalls++;
        end else begin
            m_valid   = bus16.id_valid;
            m_pc4     = bus16.id_pc4;
            m_rs_data = read_port(bus16.id_rs, bus16.id_rs_data);
            m_rt_data = read_port(bus16.id_rt, bus16.id_rt_data);
            m_imm     = bus16.id_imm;
            m_rs      = bus16.id_rs;
            m_rt      = bus16.id_rt;
            m_rd      = bus16.id_rd;
            m_ctrl    = bus16.id_valid ? 9'(bus16.id_ctrl) : 9'd0;
        end
        #1;
        if (rst_n && chk_en) begin
            check("ex_valid",   64'(bus16.ex_valid),   64'(m_valid));
            check("ex_pc4",     64'(bus16.ex_pc4),     64'(m_pc4));
            check("ex_rs_data", 64'(bus16.ex_rs_data), 64'(m_rs_data));
            check("ex_rt_data", 64'(bus16.ex_rt_data), 64'(m_rt_data));
            check("ex_imm",     64'(bus16.ex_imm),     64'(m_imm));
            check("ex_rs",      64'(bus16.ex_rs),      64'(m_rs));
            check("ex_rt",      64'(bus16.ex_rt),      64'(m_rt));
            check("ex_rd",      64'(bus16.ex_rd),      64'(m_rd));
            check("ex_ctrl",    64'(bus16.ex_ctrl),    64'(m_ctrl));
            check("stall_cnt16", 64'(bus16.stall_cnt), 64'((m_stalls > 65535) ? 65535 : m_stalls));
            check("stall_cnt4",  64'(bus4.stall_cnt),  64'((m_stalls > 15) ? 15 : m_stalls));
            check("ex4_ctrl",   64'(bus4.ex_ctrl),     64'(m_ctrl));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus16.stall = 0; bus16.flush = 0; bus16.id_valid = 0;
        bus16.id_pc4 = 0; bus16.id_rs_data = 0; bus16.id_rt_data = 0; bus16.id_imm = 0;
        bus16.id_rs = 0; bus16.id_rt = 0; bus16.id_rd = 0; bus16.id_ctrl = CTRL_NOP;
        bus16.wb_reg_write = 0; bus16.wb_rd = 0; bus16.wb_data = 0;
    endtask

    task automatic random_inputs(input bit hazards);
        ctrl_t c;
        c = ctrl_t'(9'($urandom));
        bus16.stall        = hazards ? ($urandom_range(0, 3) == 0) : 1'b1 & $urandom;
        bus16.flush        = hazards ? ($urandom_range(0, 4) == 0) : 1'b1 & $urandom;
        bus16.id_valid     = 1'($urandom);
        bus16.id_pc4       = $urandom;
        bus16.id_rs_data   = $urandom;
        bus16.id_rt_data   = $urandom;
        bus16.id_imm       = $urandom;
        bus16.id_rs        = 5'($urandom_range(0, 3));
        bus16.id_rt        = 5'($urandom_range(0, 3));
        bus16.id_rd        = 5'($urandom);
        bus16.id_ctrl      = c;
        bus16.wb_reg_write = 1'($urandom);
        bus16.wb_rd        = 5'($urandom_range(0, 3));
        bus16.wb_data      = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(bus16.ex_valid),   64'd0);
        check({tag, "_pc4"},   64'(bus16.ex_pc4),     64'd0);
        check({tag, "_rs"},    64'(bus16.ex_rs_data), 64'd0);
        check({tag, "_rt"},    64'(bus16.ex_rt_data), 64'd0);
        check({tag, "_imm"},   64'(bus16.ex_imm),     64'd0);
        check({tag, "_rd"},    64'(bus16.ex_rd),      64'd0);
        check({tag, "_ctrl"},  64'(bus16.ex_ctrl),    64'd0);
        check({tag, "_cnt"},   64'(bus16.stall_cnt),  64'd0);
        check({tag, "_cnt4"},  64'(bus4.stall_cnt),   64'd0);
    endtask

    initial begin
        ctrl_t c;
        rst_n = 1'b0;
        idle_inputs();

        // Reset held with random inputs, including stall/flush.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            random_inputs(1'b0);
        end
        step(1);
        check_all_zero("rst_hold");

        idle_inputs();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step(1);

        // Plain capture.
        c = CTRL_NOP; c.alu_src = 1'b1; c.alu_op = ALU_OP_ADD;
        bus16.id_valid = 1; bus16.id_pc4 = 32'h0000_0104;
        bus16.id_rs_data = 32'hAAAA_AAAA; bus16.id_rt_data = 32'h5555_5555;
        bus16.id_imm = 32'hFFFF_FFF0; bus16.id_rs = 5'd3; bus16.id_rt = 5'd4; bus16.id_rd = 5'd5;
        bus16.id_ctrl = c;
        step(1);
        check("cap_rs",    64'(bus16.ex_rs_data), 64'hAAAA_AAAA);
        check("cap_rt",    64'(bus16.ex_rt_data), 64'h5555_5555);
        check("cap_imm",   64'(bus16.ex_imm),     64'hFFFF_FFF0);
        check("cap_valid", 64'(bus16.ex_valid),   64'd1);
        check("cap_ctrl",  64'(bus16.ex_ctrl),    64'h008);

        // Stall three cycles while ID changes underneath.
        bus16.stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus16.id_rs_data = 32'h1000_0000 + i;
            bus16.id_pc4     = 32'h0000_0200 + 4 * i;
            step(1);
        end
        check("stall_rs",  64'(bus16.ex_rs_data), 64'hAAAA_AAAA);
        check("stall_pc4", 64'(bus16.ex_pc4),     64'h0000_0104);
        check("stall_cnt", 64'(bus16.stall_cnt),  64'd3);

        // Release: the pending ID values are captured, now with reg_write set.
        bus16.stall = 0;
        bus16.id_rs_data = 32'hCAFE_0001;
        c.reg_write = 1'b1;
        bus16.id_ctrl = c;
        step(1);
        check("rel_rs",   64'(bus16.ex_rs_data), 64'hCAFE_0001);
        check("rel_ctrl", 64'(bus16.ex_ctrl),    64'h108);

        // Flush together with stall: bubble, data held, counter untouched.
        bus16.flush = 1; bus16.stall = 1; bus16.id_rs_data = 32'hBAD0_BAD0;
        step(1);
        check("flush_valid", 64'(bus16.ex_valid),   64'd0);
        check("flush_ctrl",  64'(bus16.ex_ctrl),    64'd0);
        check("flush_rs",    64'(bus16.ex_rs_data), 64'hCAFE_0001);
        check("flush_cnt",   64'(bus16.stall_cnt),  64'd3);

        // WB bypass hits both ports at once.
        bus16.flush = 0; bus16.stall = 0;
        bus16.id_rs = 5'd8; bus16.id_rt = 5'd8; bus16.id_rs_data = 0; bus16.id_rt_data = 0;
        bus16.wb_reg_write = 1; bus16.wb_rd = 5'd8; bus16.wb_data = 32'h1234_5678;
        step(1);
        check("byp_rs", 64'(bus16.ex_rs_data), 64'h1234_5678);
        check("byp_rt", 64'(bus16.ex_rt_data), 64'h1234_5678);

        // Index 0 is never bypassed.
        bus16.id_rs = 5'd0; bus16.id_rt = 5'd0; bus16.wb_rd = 5'd0;
        bus16.id_rs_data = 32'hDEAD_0001; bus16.id_rt_data = 32'hDEAD_0002;
        step(1);
        check("byp0_rs", 64'(bus16.ex_rs_data), 64'hDEAD_0001);
        check("byp0_rt", 64'(bus16.ex_rt_data), 64'hDEAD_0002);

        // Only rt matches; then a match without wb_reg_write.
        bus16.id_rs = 5'd7; bus16.id_rt = 5'd9; bus16.wb_rd = 5'd9; bus16.wb_data = 32'h0BAD_F00D;
        step(1);
        check("bypx_rs", 64'(bus16.ex_rs_data), 64'hDEAD_0001);
        check("bypx_rt", 64'(bus16.ex_rt_data), 64'h0BAD_F00D);
        bus16.wb_reg_write = 0;
        step(1);
        check("bypoff_rt", 64'(bus16.ex_rt_data), 64'hDEAD_0002);

        // Invalid instruction: fields captured, control forced to zero.
        bus16.id_valid = 0; bus16.id_ctrl = ctrl_t'(9'h1FF); bus16.id_imm = 32'h0000_0042;
        step(1);
        check("inv_valid", 64'(bus16.ex_valid), 64'd0);
        check("inv_ctrl",  64'(bus16.ex_ctrl),  64'd0);
        check("inv_imm",   64'(bus16.ex_imm),   64'h42);

        // Long stall: 4-bit counter saturates and stays there; 16-bit keeps counting.
        bus16.stall = 1;
        step(20);
        check("sat_cnt4",  64'(bus4.stall_cnt),  64'hF);
        check("sat_cnt16", 64'(bus16.stall_cnt), 64'd23);
        step(2);
        check("sat_hold4", 64'(bus4.stall_cnt),  64'hF);
        bus16.stall = 0;

        // Mixed traffic against the model.
        for (int i = 0; i < 40; i++) begin
            random_inputs(1'b1);
            step(1);
        end

        // Asynchronous reset mid-cycle clears immediately.
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            random_inputs(1'b1);
            step(1);
        end

        chk_en = 1'b0;
        step(1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
